// File: rtl/frame_tick_sync_pkg.sv
// Shared state encoding and default timing constants for the frame tick synchroniser.
package frame_tick_sync_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEARCH  = 3'd1,
        MEASURE = 3'd2,
        LOCKED  = 3'd3,
        LOST    = 3'd4
    } state_t;

    // The divider toggles its output every DIV_TC cycles, so one full slow period is two of those.
    localparam int unsigned DIV_TC          = 500001;
    localparam int unsigned DEF_NOM_PERIOD  = 2 * DIV_TC;
    localparam int unsigned DEF_TOL         = 1000;
    localparam int unsigned DEF_TIMEOUT     = 2 * DEF_NOM_PERIOD;
    localparam int unsigned DEF_LOCK_COUNT  = 4;
    localparam int unsigned DEF_PW          = 21;

endpackage

// File: rtl/frame_tick_sync_edge_detect.sv
// Multi-flop synchroniser for the slow divided clock, plus a history flop for rising-edge detect.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            hist  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            hist  <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/frame_tick_sync.sv
// Turns the synchronised slow clock into frame ticks, measures its period and tracks lock.
//   state   | meaning
//   IDLE    | disabled, counters cleared
//   SEARCH  | waiting for the first edge to start a measurement
//   MEASURE | counting consecutive in-tolerance periods
//   LOCKED  | stable input, frame ticks delivered
//   LOST    | no edge for TIMEOUT cycles while locked
module frame_tick_sync
    import frame_tick_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NOM_PERIOD  = DEF_NOM_PERIOD,
    parameter int unsigned TOL         = DEF_TOL,
    parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned PW          = DEF_PW
) (
    input  logic          clock50mHz,
    input  logic          reset,
    input  logic          enable,
    input  logic          slow_clk_in,
    output logic          tick_pulse,
    output logic          frame_tick,
    output logic [15:0]   frame_count,
    output logic [PW-1:0] period_last,
    output logic          locked,
    output logic          tick_lost
);

    localparam int unsigned GCW = $clog2(LOCK_COUNT + 1);
    localparam logic [PW-1:0]  CNT_MAX   = PW'(TIMEOUT);
    localparam logic [PW-1:0]  PER_LO    = PW'(NOM_PERIOD - TOL);
    localparam logic [PW-1:0]  PER_HI    = PW'(NOM_PERIOD + TOL);
    localparam logic [PW-1:0]  CNT_ONE   = PW'(1);
    localparam logic [GCW-1:0] GC_ONE    = GCW'(1);
    localparam logic [GCW-1:0] GC_LAST   = GCW'(LOCK_COUNT - 1);

    state_t         state;
    logic [PW-1:0]  cnt;
    logic [PW-1:0]  period;
    logic [GCW-1:0] good_cnt;
    logic           rise;
    logic           good;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clock50mHz),
        .rst_n (reset),
        .din   (slow_clk_in),
        .rise  (rise)
    );

    // Period ends on the edge cycle itself, hence the +1 on the running count.
    assign period = cnt + CNT_ONE;
    assign good   = (period >= PER_LO) && (period <= PER_HI);

    always_ff @(posedge clock50mHz or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            good_cnt    <= '0;
            tick_pulse  <= 1'b0;
            frame_tick  <= 1'b0;
            frame_count <= '0;
            period_last <= '0;
            locked      <= 1'b0;
            tick_lost   <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            cnt        <= '0;
            good_cnt   <= '0;
            tick_pulse <= 1'b0;
            frame_tick <= 1'b0;
            locked     <= 1'b0;
            tick_lost  <= 1'b0;
        end else begin
            tick_pulse <= rise && (state != IDLE);
            frame_tick <= 1'b0;

            if (rise)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_ONE;

            case (state)
                IDLE: state <= SEARCH;

                SEARCH: if (rise) begin
                    state    <= MEASURE;
                    good_cnt <= '0;
                end

                MEASURE: if (rise) begin
                    period_last <= period;
                    if (good) begin
                        good_cnt <= good_cnt + GC_ONE;
                        if (good_cnt == GC_LAST) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else begin
                        good_cnt <= '0;
                    end
                end

                // An edge arriving together with the timeout is judged as a (bad) period.
                LOCKED: if (rise) begin
                    period_last <= period;
                    if (good) begin
                        frame_tick  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        state    <= MEASURE;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end
                end else if (cnt == CNT_MAX) begin
                    state     <= LOST;
                    locked    <= 1'b0;
                    tick_lost <= 1'b1;
                end

                LOST: if (rise) begin
                    period_last <= period;
                    state       <= MEASURE;
                    good_cnt    <= '0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_tick_sync.sv
// Directed bench for frame_tick_sync: latency, lock/tolerance table, loss, wrap, enable and async reset.
module tb_frame_tick_sync;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        slow_clk_in;
    logic        tick_pulse;
    logic        frame_tick;
    logic [15:0] frame_count;
    logic [20:0] period_last;
    logic        locked;
    logic        tick_lost;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          p_next;
        logic        tick;
        logic        ft;
        logic        lk;
        logic [20:0] pl;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs[18];

    frame_tick_sync #(
        .SYNC_STAGES (2),
        .NOM_PERIOD  (100),
        .TOL         (2),
        .LOCK_COUNT  (4),
        .TIMEOUT     (200),
        .PW          (21)
    ) dut (
        .clock50mHz  (clk),
        .reset       (rst_n),
        .enable      (enable),
        .slow_clk_in (slow_clk_in),
        .tick_pulse  (tick_pulse),
        .frame_tick  (frame_tick),
        .frame_count (frame_count),
        .period_last (period_last),
        .locked      (locked),
        .tick_lost   (tick_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int p, input int t, input int f, input int l,
                                input int pl, input int fc);
        vec_t v;
        v.p_next = p;
        v.tick   = 1'(t);
        v.ft     = 1'(f);
        v.lk     = 1'(l);
        v.pl     = 21'(pl);
        v.fc     = 16'(fc);
        return v;
    endfunction

    // Called 3 negedges after a rise was driven; completes a period of p cycles and drives the next rise.
    task automatic rest(input int p);
        @(negedge clk);
        chk("tick_width", 64'(tick_pulse), 64'd0);
        repeat (p / 2 - 4) @(negedge clk);
        slow_clk_in = 1'b0;
        repeat (p - p / 2) @(negedge clk);
        slow_clk_in = 1'b1;
    endtask

    task automatic relock4();
        for (int i = 0; i < 4; i++) begin
            repeat (3) @(negedge clk);
            chk($sformatf("relock_%0d", i), 64'(locked), 64'(i == 3));
            rest(100);
        end
    endtask

    initial begin
        // period that follows each rise, then expected tick, frame_tick, locked, period_last, frame_count
        vecs[0]  = mk(100, 1, 0, 0, 100, 0);
        vecs[1]  = mk(100, 1, 0, 0, 100, 0);
        vecs[2]  = mk(100, 1, 0, 0, 100, 0);
        vecs[3]  = mk(100, 1, 0, 1, 100, 0);
        vecs[4]  = mk( 98, 1, 1, 1, 100, 1);
        vecs[5]  = mk(102, 1, 1, 1,  98, 2);
        vecs[6]  = mk(103, 1, 1, 1, 102, 3);
        vecs[7]  = mk(100, 1, 0, 0, 103, 3);
        vecs[8]  = mk( 99, 1, 0, 0, 100, 3);
        vecs[9]  = mk(101, 1, 0, 0,  99, 3);
        vecs[10] = mk(100, 1, 0, 0, 101, 3);
        vecs[11] = mk(100, 1, 0, 1, 100, 3);
        vecs[12] = mk( 97, 1, 1, 1, 100, 4);
        vecs[13] = mk(100, 1, 0, 0,  97, 4);
        vecs[14] = mk(100, 1, 0, 0, 100, 4);
        vecs[15] = mk(100, 1, 0, 0, 100, 4);
        vecs[16] = mk(100, 1, 0, 0, 100, 4);
        vecs[17] = mk(100, 1, 0, 1, 100, 4);

        rst_n       = 1'b0;
        enable      = 1'b0;
        slow_clk_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({tick_pulse, frame_tick, frame_count, period_last, locked, tick_lost}), 64'd0);

        rst_n  = 1'b1;
        enable = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            chk($sformatf("latency_c%0d", c), 64'(tick_pulse), 64'(c == 13));
            if (c == 12)
                chk("pre_edge_zero", 64'({frame_tick, frame_count, period_last, locked, tick_lost}), 64'd0);
            if (c == 10)
                slow_clk_in = 1'b1;
        end
        rest(100);

        for (int i = 0; i < 18; i++) begin
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_tick", i), 64'(tick_pulse), 64'(vecs[i].tick));
            chk($sformatf("vec%0d_frame_tick", i), 64'(frame_tick), 64'(vecs[i].ft));
            chk($sformatf("vec%0d_locked", i), 64'(locked), 64'(vecs[i].lk));
            chk($sformatf("vec%0d_period", i), 64'(period_last), 64'(vecs[i].pl));
            chk($sformatf("vec%0d_count", i), 64'(frame_count), 64'(vecs[i].fc));
            chk($sformatf("vec%0d_lost", i), 64'(tick_lost), 64'd0);
            rest(vecs[i].p_next);
        end

        // Last good locked edge, then the input stops.
        repeat (3) @(negedge clk);
        chk("last_edge_frame_tick", 64'(frame_tick), 64'd1);
        chk("last_edge_count", 64'(frame_count), 64'd5);
        repeat (47) @(negedge clk);
        slow_clk_in = 1'b0;
        // cnt reaches TIMEOUT 200 cycles past the edge cycle; the state changes on the following clock.
        repeat (153) @(negedge clk);
        chk("timeout_not_yet_locked", 64'(locked), 64'd1);
        chk("timeout_not_yet_lost", 64'(tick_lost), 64'd0);
        @(negedge clk);
        chk("timeout_locked", 64'(locked), 64'd0);
        chk("timeout_lost", 64'(tick_lost), 64'd1);
        repeat (6) @(negedge clk);
        slow_clk_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("lost_edge_tick", 64'(tick_pulse), 64'd1);
        chk("lost_edge_sticky", 64'(tick_lost), 64'd1);
        chk("lost_edge_period_sat", 64'(period_last), 64'd201);
        chk("lost_edge_frame_tick", 64'(frame_tick), 64'd0);
        rest(100);
        relock4();

        // Preload just below the wrap point; 65536 real frames would not fit the cycle budget.
        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.frame_count;
        repeat (3) @(negedge clk);
        chk("wrap_frame_tick", 64'(frame_tick), 64'd1);
        chk("wrap_count", 64'(frame_count), 64'd0);
        rest(100);
        repeat (3) @(negedge clk);
        chk("post_wrap_count", 64'(frame_count), 64'd1);
        chk("post_wrap_lost_sticky", 64'(tick_lost), 64'd1);

        enable = 1'b0;
        @(negedge clk);
        chk("disable_locked", 64'(locked), 64'd0);
        chk("disable_lost_clear", 64'(tick_lost), 64'd0);
        chk("disable_count_held", 64'(frame_count), 64'd1);
        chk("disable_period_held", 64'(period_last), 64'd100);
        repeat (10) @(negedge clk);
        enable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("reenable_no_tick_%0d", c), 64'(tick_pulse), 64'd0);
        end
        slow_clk_in = 1'b0;
        repeat (10) @(negedge clk);
        slow_clk_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("search_edge_tick", 64'(tick_pulse), 64'd1);
        chk("search_edge_period_held", 64'(period_last), 64'd100);
        chk("search_edge_locked", 64'(locked), 64'd0);
        rest(100);
        relock4();

        repeat (3) @(negedge clk);
        chk("pre_reset_frame_tick", 64'(frame_tick), 64'd1);
        chk("pre_reset_count", 64'(frame_count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({tick_pulse, frame_tick, frame_count, period_last, locked, tick_lost}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("after_reset_locked", 64'(locked), 64'd0);
        chk("after_reset_count", 64'(frame_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
